apb_arbiter: RTL and testbench

- Two-master, one-slave APB arbiter that shares the single system APB bus between the CPU core (master 0) and a secondary master (master 1, e.g. a debug/DMA engine).
- Each master drives a full APB master interface into this block. The arbiter picks one master with round-robin priority and replays the transfer on the shared bus as a registered SETUP/ACCESS sequence.
- It returns pready/prdata/perr to the granted master only, and aborts with an error when a slave hangs.

---
 rtl/apb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_apb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-master round-robin APB arbiter that replays the granted request on one shared slave bus.
// Latency: request seen in IDLE -> SETUP next cycle -> ACCESS after that; a zero-wait slave completes 2 cycles after the request.
// Backpressure: masters hold psel until pready; slave wait states stretch ACCESS, which is capped by TIMEOUT.
module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  output logic [ADDR_WIDTH-1:0] APB_paddr,
  output logic [DATA_WIDTH-1:0] APB_pdata,
  output logic                  APB_psel,
  output logic                  APB_penable,
  output logic                  APB_pwrite,
  output logic [3:0]            APB_pstb,
  input  logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_pready,
  input  logic                  APB_perr,
  output logic                  grant
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // disabled configuration still elaborates cleanly.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [3:0]              pstb_q, pstb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    arb_sel;
  logic                    timeout_hit;
  logic                    xfer_done;
  logic                    req_held;
  logic                    rsp_vld;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_dat;

  // penable from the masters carries no information the arbiter needs.
  logic                    unused_penable;
  assign unused_penable = m0_penable | m1_penable;

  // On a tie the master that did not win last time gets the bus.
  assign arb_sel     = (m0_psel && m1_psel) ? ~last_grant_q : m1_psel;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && (cnt_q == CNT_LAST);
  assign xfer_done   = (state_q == ACCESS) && (APB_pready || timeout_hit);

  // A granted master that dropped psel early loses its response; the bus
  // transfer still runs to completion.
  assign req_held = last_grant_q ? m1_psel : m0_psel;
  assign rsp_vld  = xfer_done && req_held;
  assign rsp_err  = APB_perr || (timeout_hit && !APB_pready);
  assign rsp_dat  = APB_pready ? APB_prdata : '0;

  assign APB_paddr   = paddr_q;
  assign APB_pdata   = pdata_q;
  assign APB_psel    = psel_q;
  assign APB_penable = penable_q;
  assign APB_pwrite  = pwrite_q;
  assign APB_pstb    = pstb_q;
  assign grant       = last_grant_q;

  // State register and registered shared-bus outputs.
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pdata_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pstb_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pdata_q      <= pdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pstb_q       <= pstb_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next state: arbitrate and latch in IDLE, enable in SETUP, hold until done in ACCESS.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pdata_d      = pdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pstb_d       = pstb_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (m0_psel || m1_psel) begin
          last_grant_d = arb_sel;
          paddr_d      = arb_sel ? m1_paddr  : m0_paddr;
          pdata_d      = arb_sel ? m1_pdata  : m0_pdata;
          pwrite_d     = arb_sel ? m1_pwrite : m0_pwrite;
          pstb_d       = arb_sel ? m1_pstb   : m0_pstb;
          psel_d       = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (xfer_done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Route the completion back to the granted master only.
  always_comb begin
    m0_pready = 1'b0;
    m0_perr   = 1'b0;
    m0_prdata = '0;
    m1_pready = 1'b0;
    m1_perr   = 1'b0;
    m1_prdata = '0;
    if (rsp_vld) begin
      if (last_grant_q) begin
        m1_pready = 1'b1;
        m1_perr   = rsp_err;
        m1_prdata = rsp_dat;
      end else begin
        m0_pready = 1'b1;
        m0_perr   = rsp_err;
        m0_prdata = rsp_dat;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: random masters and slave against a transaction-level model.
// Latency: inputs driven 1ns after each rising edge, outputs checked 2ns after it.
// Backpressure: bench masters hold requests until pready; bench slave inserts random waits.
module tb_apb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          APB_PCLK   = 1'b0;
  logic          APB_PRESET = 1'b1;
  logic [AW-1:0] m0_paddr = '0, m1_paddr = '0;
  logic [DW-1:0] m0_pdata = '0, m1_pdata = '0;
  logic          m0_psel = 1'b0, m1_psel = 1'b0;
  logic          m0_penable = 1'b0, m1_penable = 1'b0;
  logic          m0_pwrite = 1'b0, m1_pwrite = 1'b0;
  logic [3:0]    m0_pstb = '0, m1_pstb = '0;
  logic [DW-1:0] m0_prdata, m1_prdata;
  logic          m0_pready, m1_pready, m0_perr, m1_perr;
  logic [AW-1:0] APB_paddr;
  logic [DW-1:0] APB_pdata;
  logic          APB_psel, APB_penable, APB_pwrite;
  logic [3:0]    APB_pstb;
  logic [DW-1:0] APB_prdata = '0;
  logic          APB_pready = 1'b0, APB_perr = 1'b0;
  logic          grant;

  always #5 APB_PCLK = ~APB_PCLK;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .APB_PCLK(APB_PCLK), .APB_PRESET(APB_PRESET),
    .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
    .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
    .m0_perr(m0_perr),
    .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
    .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
    .m1_perr(m1_perr),
    .APB_paddr(APB_paddr), .APB_pdata(APB_pdata), .APB_psel(APB_psel), .APB_penable(APB_penable),
    .APB_pwrite(APB_pwrite), .APB_pstb(APB_pstb), .APB_prdata(APB_prdata),
    .APB_pready(APB_pready), .APB_perr(APB_perr), .grant(grant)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Bench masters
  bit          req[2];
  logic [31:0] m_addr[2], m_wdat[2];
  bit          m_wr[2];
  logic [3:0]  m_stb[2];
  bit          got_rdy[2];
  int          p_req[2];
  bit          rst_req = 1'b1;

  // Bench slave
  int          w_min = 0, w_max = 0, w_cur = 0, k = 0;
  bit          s_err;
  logic [31:0] s_rdata;
  bit          rd_force_en = 1'b0;
  logic [31:0] rd_force = '0;

  // Reference model and logs
  bit          prev_idle = 1'b1, prev_setup = 1'b0, prev_acc = 1'b0, prev_done = 1'b0, prev_rst = 1'b1;
  bit          prev_r[2];
  logic [31:0] prev_addr[2], prev_wdat[2];
  bit          prev_wr[2];
  logic [3:0]  prev_stb[2];
  int          owner = 0, last = 1;
  logic [31:0] x_addr, x_wdat;
  bit          x_wr;
  logic [3:0]  x_stb;
  int          own_log[$];
  logic [31:0] addr_log[$];
  int          acc_len = 0, last_len = 0, cyc = 0, done_cyc = 0, req_cyc = 0;
  bit          last_err;
  logic [31:0] last_data;
  logic [3:0]  last_stb;
  int          cnt_rdy[2];

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d,
                         input bit w, input logic [3:0] s);
    req[m] = 1'b1; m_addr[m] = a; m_wdat[m] = d; m_wr[m] = w; m_stb[m] = s;
  endtask

  task automatic cycle();
    bit in_setup, in_acc, exp_setup, exp_acc, done, exp_err;
    logic [31:0] exp_data;
    done = 1'b0; exp_err = 1'b0; exp_data = '0;
    @(posedge APB_PCLK); #1;
    cyc++;
    APB_PRESET = rst_req;
    for (int m = 0; m < 2; m++) begin
      if (got_rdy[m]) req[m] = 1'b0;
      if (!req[m] && ($urandom_range(99) < 32'(p_req[m])))
        set_req(m, $urandom, $urandom, 1'($urandom_range(1)), 4'($urandom_range(15)));
    end
    m0_psel = req[0]; m0_paddr = m_addr[0]; m0_pdata = m_wdat[0]; m0_pwrite = m_wr[0]; m0_pstb = m_stb[0];
    m1_psel = req[1]; m1_paddr = m_addr[1]; m1_pdata = m_wdat[1]; m1_pwrite = m_wr[1]; m1_pstb = m_stb[1];
    m0_penable = req[0]; m1_penable = req[1];
    in_setup = APB_psel && !APB_penable;
    in_acc   = APB_psel && APB_penable;
    if (in_setup) begin
      w_cur   = $urandom_range(w_max, w_min);
      s_err   = 1'($urandom_range(1));
      s_rdata = rd_force_en ? rd_force : $urandom;
      k       = -1;
    end
    if (in_acc) k++;
    APB_pready = in_acc && (k == w_cur);
    APB_perr   = APB_pready && s_err;
    APB_prdata = in_acc ? s_rdata : $urandom;
    #1;
    if (prev_rst) begin
      last = 1;
      chk("rst_psel", 64'(APB_psel), 64'(0));
      chk("rst_penable", 64'(APB_penable), 64'(0));
      chk("rst_bus", 64'({APB_paddr, APB_pwrite, APB_pstb}), 64'(0));
      chk("rst_pdata", 64'(APB_pdata), 64'(0));
    end
    exp_setup = !prev_rst && prev_idle && (prev_r[0] || prev_r[1]);
    exp_acc   = !prev_rst && (prev_setup || (prev_acc && !prev_done));
    chk("setup_when", 64'(in_setup), 64'(exp_setup));
    chk("access_when", 64'(in_acc), 64'(exp_acc));
    if (in_setup && exp_setup) begin
      owner  = (prev_r[0] && prev_r[1]) ? 1 - last : (prev_r[1] ? 1 : 0);
      last   = owner;
      x_addr = prev_addr[owner]; x_wdat = prev_wdat[owner];
      x_wr   = prev_wr[owner];   x_stb  = prev_stb[owner];
      own_log.push_back(owner);
      addr_log.push_back(APB_paddr);
      acc_len = 0;
    end
    chk("grant", 64'(grant), 64'(last));
    if ((in_setup && exp_setup) || (in_acc && exp_acc)) begin
      chk("bus_addr", 64'(APB_paddr), 64'(x_addr));
      chk("bus_wdat", 64'(APB_pdata), 64'(x_wdat));
      chk("bus_ctl", 64'({APB_pwrite, APB_pstb}), 64'({x_wr, x_stb}));
    end
    if (in_acc && exp_acc) begin
      acc_len++;
      done     = (k == w_cur) || (k == TO - 1);
      exp_err  = (k == w_cur) ? s_err : 1'b1;
      exp_data = (k == w_cur) ? s_rdata : 32'h0;
    end
    chk("m0_pready", 64'(m0_pready), 64'(done && owner == 0));
    chk("m1_pready", 64'(m1_pready), 64'(done && owner == 1));
    chk("m0_perr", 64'(m0_perr), 64'(done && owner == 0 && exp_err));
    chk("m1_perr", 64'(m1_perr), 64'(done && owner == 1 && exp_err));
    if (done) begin
      chk("own_prdata", 64'(owner == 1 ? m1_prdata : m0_prdata), 64'(exp_data));
      chk("other_prdata", 64'(owner == 1 ? m0_prdata : m1_prdata), 64'(0));
      last_len  = acc_len;
      last_err  = owner == 1 ? m1_perr : m0_perr;
      last_data = owner == 1 ? m1_prdata : m0_prdata;
      last_stb  = APB_pstb;
      done_cyc  = cyc;
    end
    got_rdy[0] = m0_pready; got_rdy[1] = m1_pready;
    cnt_rdy[0] += int'(m0_pready); cnt_rdy[1] += int'(m1_pready);
    prev_idle = !APB_psel; prev_setup = in_setup; prev_acc = in_acc;
    prev_done = done; prev_rst = APB_PRESET;
    for (int m = 0; m < 2; m++) begin
      prev_r[m] = req[m]; prev_addr[m] = m_addr[m]; prev_wdat[m] = m_wdat[m];
      prev_wr[m] = m_wr[m]; prev_stb[m] = m_stb[m];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    req = '{1'b0, 1'b0}; got_rdy = '{1'b0, 1'b0};
    cycle();
    rst_req = 1'b0;
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int tgt;
    tgt = cnt_rdy[0] + cnt_rdy[1] + n;
    for (int i = 0; i < budget && (cnt_rdy[0] + cnt_rdy[1]) < tgt; i++) cycle();
    chk(tag, 64'((cnt_rdy[0] + cnt_rdy[1]) >= tgt), 64'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (req[0] || req[1] || APB_psel); i++) cycle();
    chk("drain", 64'(req[0] || req[1] || APB_psel), 64'(0));
  endtask

  initial begin
    p_req = '{0, 0}; cnt_rdy = '{0, 0};
    do_reset();

    // Single zero-wait read from master 0
    rd_force_en = 1'b1; rd_force = 32'hDEADBEEF; w_min = 0; w_max = 0;
    set_req(0, 32'h2000, 32'h0, 1'b0, 4'hF);
    req_cyc = cyc + 1;
    wait_xfers("t1_wait", 1, 10);
    chk("t1_latency", 64'(done_cyc - req_cyc), 64'(2));
    chk("t1_rdata", 64'(last_data), 64'(32'hDEADBEEF));
    chk("t1_m1_quiet", 64'(cnt_rdy[1]), 64'(0));
    run(3);
    rd_force_en = 1'b0;

    // Tie straight after reset: master 0 first, then master 1
    do_reset();
    own_log.delete(); addr_log.delete();
    set_req(0, 32'h10, 32'h11, 1'b1, 4'hF);
    set_req(1, 32'h20, 32'h22, 1'b1, 4'hF);
    wait_xfers("t2_wait", 2, 20);
    chk("t2_first", 64'(own_log[0]), 64'(0));
    chk("t2_second", 64'(own_log[1]), 64'(1));
    chk("t2_addr0", 64'(addr_log[0]), 64'(32'h10));
    chk("t2_addr1", 64'(addr_log[1]), 64'(32'h20));
    drain();

    // Both masters requesting continuously must alternate
    own_log.delete(); p_req = '{100, 100}; w_min = 0; w_max = 2;
    wait_xfers("t3_wait", 8, 80);
    p_req = '{0, 0};
    drain();
    for (int i = 1; i < 8; i++) chk("t3_alternate", 64'(own_log[i]), 64'(1 - own_log[i-1]));

    // Five wait states on a master 1 write with partial strobes
    w_min = 5; w_max = 5; cnt_rdy = '{0, 0};
    set_req(1, 32'h3000, 32'hA5A5_0000, 1'b1, 4'b0011);
    wait_xfers("t4_wait", 1, 20);
    run(4);
    chk("t4_access_len", 64'(last_len), 64'(6));
    chk("t4_pstb", 64'(last_stb), 64'(4'b0011));
    chk("t4_one_pulse", 64'(cnt_rdy[1]), 64'(1));

    // Slave never answers: forced error completion after TO access cycles
    w_min = 1000; w_max = 1000;
    set_req(0, 32'h4000, 32'h0, 1'b0, 4'hF);
    wait_xfers("t5_wait", 1, 30);
    chk("t5_access_len", 64'(last_len), 64'(TO));
    chk("t5_err", 64'(last_err), 64'(1));
    chk("t5_rdata", 64'(last_data), 64'(0));
    w_min = 0; w_max = 0; own_log.delete();
    run(1);
    set_req(1, 32'h4004, 32'h0, 1'b0, 4'hF);
    wait_xfers("t5_next", 1, 10);
    chk("t5_next_owner", 64'(own_log[0]), 64'(1));
    drain();

    // Reset in the middle of an ACCESS phase
    w_min = 1000; w_max = 1000;
    set_req(0, 32'h5000, 32'h0, 1'b0, 4'hF);
    for (int i = 0; i < 10 && !(APB_psel && APB_penable && k == 2); i++) cycle();
    chk("t6_in_access", 64'(APB_psel && APB_penable), 64'(1));
    cnt_rdy = '{0, 0};
    do_reset();
    run(3);
    chk("t6_no_pready", 64'(cnt_rdy[0] + cnt_rdy[1]), 64'(0));
    w_min = 0; w_max = 0; own_log.delete();
    set_req(0, 32'h6000, 32'h0, 1'b0, 4'hF);
    set_req(1, 32'h6004, 32'h0, 1'b0, 4'hF);
    wait_xfers("t6_wait", 2, 20);
    chk("t6_tie_first", 64'(own_log[0]), 64'(0));
    drain();

    // Random traffic with random waits, some long enough to hit the timeout
    w_min = 0; w_max = 9;
    for (int b = 0; b < 10; b++) begin
      p_req[0] = $urandom_range(80, 10);
      p_req[1] = $urandom_range(80, 10);
      run(200);
    end
    p_req = '{0, 0};
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
